// File: rtl/fifo_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_chk_pkg
// Description : Shared definitions for the multi-channel FIFO protocol
//               checker: error-vector bit positions and the error-vector type.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_chk_pkg;

    // Bit positions inside a per-channel error vector
    localparam int ERR_FULL        = 0;
    localparam int ERR_EMPTY       = 1;
    localparam int ERR_ALMOSTFULL  = 2;
    localparam int ERR_ALMOSTEMPTY = 3;
    localparam int ERR_WR_ACK      = 4;
    localparam int ERR_OVERFLOW    = 5;
    localparam int ERR_UNDERFLOW   = 6;
    localparam int ERR_DATA        = 7;

    typedef logic [7:0] err_vec_t;

endpackage
`default_nettype wire

// File: rtl/fifo_chk_chan.sv
`default_nettype none
// ============================================================================
// Module      : fifo_chk_chan
// Description : One channel of the FIFO protocol checker. Keeps a shadow
//               occupancy count of the monitored FIFO, derives expected
//               combinational flags and registered responses, and latches
//               mismatches into a sticky vector and a saturating counter.
//               Optional FIFO_CHK_DATA_EN builds a shadow RAM that checks
//               read data.
// Ports       : clk, rst_n          - clock, async active-low reset
//               en, clr             - check enable, sync clear of error state
//               wr_en, rd_en        - strobes seen by the monitored FIFO
//               full..almostempty   - monitored combinational flags
//               wr_ack..underflow   - monitored registered responses
//               data_in, data_out   - monitored data (FIFO_CHK_DATA_EN only)
//               err_flags, err_cnt  - sticky vector, saturating counter
//               mis_vec             - this cycle's enabled mismatch vector
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_chk_chan
    import fifo_chk_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             full,
    input  logic             empty,
    input  logic             almostfull,
    input  logic             almostempty,
    input  logic             wr_ack,
    input  logic             overflow,
    input  logic             underflow,
    input  logic [W-1:0]     data_in,
    input  logic [W-1:0]     data_out,
    output err_vec_t         err_flags,
    output logic [CNT_W-1:0] err_cnt,
    output err_vec_t         mis_vec
);

    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AFULL = c_CW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    logic [c_CW-1:0]  r_cnt;
    logic             r_warm;
    logic             r_exp_ack;
    logic             r_exp_ovf;
    logic             r_exp_udf;
    err_vec_t         r_flags;
    logic [CNT_W-1:0] r_ecnt;

    logic     w_full_exp;
    logic     w_empty_exp;
    logic     w_afull_exp;
    logic     w_aempty_exp;
    logic     w_wr_ok;
    logic     w_rd_ok;
    logic     w_data_mis;
    err_vec_t w_mis;

    // Expectations come from the count before this cycle's update
    assign w_full_exp   = (r_cnt == c_FULL);
    assign w_empty_exp  = (r_cnt == '0);
    assign w_afull_exp  = (r_cnt == c_AFULL);
    assign w_aempty_exp = (r_cnt == c_ONE);

    // Count never exceeds DEPTH, so "not full" equals cnt<DEPTH. This makes a
    // write+read at full accept only the read, and at empty only the write.
    assign w_wr_ok = wr_en & ~w_full_exp;
    assign w_rd_ok = rd_en & ~w_empty_exp;

    // Shadow occupancy; tracks regardless of en and clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + c_ONE;
                2'b01:   r_cnt <= r_cnt - c_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Registered-response expectations, compared one edge later. r_warm
    // masks the compare until a first edge has latched real expectations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm    <= 1'b0;
            r_exp_ack <= 1'b0;
            r_exp_ovf <= 1'b0;
            r_exp_udf <= 1'b0;
        end else begin
            r_warm    <= 1'b1;
            r_exp_ack <= w_wr_ok;
            r_exp_ovf <= wr_en & w_full_exp;
            r_exp_udf <= rd_en & w_empty_exp;
        end
    end

`ifdef FIFO_CHK_DATA_EN
    localparam int              c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_PW-1:0] c_PONE = c_PW'(1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [W-1:0]    r_exp_dout;
    logic            r_dvalid;

    // Storage array carries no reset; only accepted writes land in it
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_exp_dout <= '0;
            r_dvalid   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + c_PONE;
            end
            if (w_rd_ok) begin
                r_rptr     <= (r_rptr == c_LAST) ? '0 : r_rptr + c_PONE;
                r_exp_dout <= r_mem[r_rptr];
            end
            r_dvalid <= w_rd_ok;
        end
    end

    assign w_data_mis = r_dvalid & (data_out != r_exp_dout);
`else
    logic w_unused_data;

    assign w_unused_data = ^{data_in, data_out};
    assign w_data_mis    = 1'b0;
`endif

    always_comb begin
        w_mis                  = '0;
        w_mis[ERR_FULL]        = full ^ w_full_exp;
        w_mis[ERR_EMPTY]       = empty ^ w_empty_exp;
        w_mis[ERR_ALMOSTFULL]  = almostfull ^ w_afull_exp;
        w_mis[ERR_ALMOSTEMPTY] = almostempty ^ w_aempty_exp;
        w_mis[ERR_WR_ACK]      = r_warm & (wr_ack ^ r_exp_ack);
        w_mis[ERR_OVERFLOW]    = r_warm & (overflow ^ r_exp_ovf);
        w_mis[ERR_UNDERFLOW]   = r_warm & (underflow ^ r_exp_udf);
        w_mis[ERR_DATA]        = w_data_mis;
    end

    assign mis_vec = en ? w_mis : '0;

    // Sticky vector and per-cycle saturating counter; clr wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
            r_ecnt  <= '0;
        end else if (clr) begin
            r_flags <= '0;
            r_ecnt  <= '0;
        end else if (|mis_vec) begin
            r_flags <= r_flags | mis_vec;
            if (r_ecnt != '1) begin
                r_ecnt <= r_ecnt + CNT_W'(1);
            end
        end
    end

    assign err_flags = r_flags;
    assign err_cnt   = r_ecnt;

endmodule
`default_nettype wire

// File: rtl/fifo_chk_multi.sv
`default_nettype none
// ============================================================================
// Module      : fifo_chk_multi
// Description : Multi-channel FIFO protocol checker. Instantiates one checker
//               channel per monitored FIFO, and holds the first-error capture
//               (lowest-index channel wins on a shared edge) and err_any.
//               Optional feature: define FIFO_CHK_DATA_EN to enable shadow
//               RAM data checking (error bit 7); otherwise bit 7 is 0.
// Ports       : clk, rst_n            - clock, async active-low reset
//               en, clr               - check enable, sync clear
//               wr_en, rd_en          - per-channel strobes [CH]
//               full..almostempty     - per-channel flags [CH]
//               wr_ack..underflow     - per-channel responses [CH]
//               data_in, data_out     - channel c at [c*W +: W]
//               err_flags             - channel c at [c*8 +: 8]
//               err_cnt               - channel c at [c*CNT_W +: CNT_W]
//               err_any               - any sticky error bit set
//               first_err_valid/ch/code - first-error capture
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_chk_multi
    import fifo_chk_pkg::*;
#(
    parameter int  CH     = 4,
    parameter int  DEPTH  = 8,
    parameter int  W      = 16,
    parameter int  CNT_W  = 8,
    localparam int c_CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [CH-1:0]       wr_en,
    input  logic [CH-1:0]       rd_en,
    input  logic [CH-1:0]       full,
    input  logic [CH-1:0]       empty,
    input  logic [CH-1:0]       almostfull,
    input  logic [CH-1:0]       almostempty,
    input  logic [CH-1:0]       wr_ack,
    input  logic [CH-1:0]       overflow,
    input  logic [CH-1:0]       underflow,
    input  logic [CH*W-1:0]     data_in,
    input  logic [CH*W-1:0]     data_out,
    output logic [CH*8-1:0]     err_flags,
    output logic [CH*CNT_W-1:0] err_cnt,
    output logic                err_any,
    output logic                first_err_valid,
    output logic [c_CH_W-1:0]   first_err_ch,
    output logic [7:0]          first_err_code
);

    err_vec_t w_mis [CH];

    logic              w_hit;
    logic [c_CH_W-1:0] w_hit_ch;
    err_vec_t          w_hit_code;

    logic              r_err_any;
    logic              r_first_valid;
    logic [c_CH_W-1:0] r_first_ch;
    err_vec_t          r_first_code;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        fifo_chk_chan #(
            .DEPTH (DEPTH),
            .W     (W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .clr         (clr),
            .wr_en       (wr_en[c]),
            .rd_en       (rd_en[c]),
            .full        (full[c]),
            .empty       (empty[c]),
            .almostfull  (almostfull[c]),
            .almostempty (almostempty[c]),
            .wr_ack      (wr_ack[c]),
            .overflow    (overflow[c]),
            .underflow   (underflow[c]),
            .data_in     (data_in[c*W +: W]),
            .data_out    (data_out[c*W +: W]),
            .err_flags   (err_flags[c*8 +: 8]),
            .err_cnt     (err_cnt[c*CNT_W +: CNT_W]),
            .mis_vec     (w_mis[c])
        );
    end

    // Lowest-index erring channel: scan downward so the last hit is lowest
    always_comb begin
        w_hit      = 1'b0;
        w_hit_ch   = '0;
        w_hit_code = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (|w_mis[i]) begin
                w_hit      = 1'b1;
                w_hit_ch   = c_CH_W'(i);
                w_hit_code = w_mis[i];
            end
        end
    end

    // err_any is kept as its own register; it tracks the OR of the sticky
    // vectors because both set on the same mismatch and clear on the same clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_any     <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
            r_first_code  <= '0;
        end else if (clr) begin
            r_err_any     <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
            r_first_code  <= '0;
        end else if (w_hit) begin
            r_err_any <= 1'b1;
            if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_ch    <= w_hit_ch;
                r_first_code  <= w_hit_code;
            end
        end
    end

    assign err_any         = r_err_any;
    assign first_err_valid = r_first_valid;
    assign first_err_ch    = r_first_ch;
    assign first_err_code  = r_first_code;

endmodule
`default_nettype wire

// File: tb/tb_fifo_chk_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_chk_multi
// Description : Directed self-checking bench for fifo_chk_multi. A small
//               behavioural FIFO model drives flags and responses; selected
//               flags/responses/data are corrupted on purpose and the checker
//               outputs are compared with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_chk_multi;

    localparam int CH    = 4;
    localparam int DEPTH = 8;
    localparam int W     = 16;
    localparam int CNT_W = 8;

`ifdef FIFO_CHK_DATA_EN
    localparam logic [7:0] c_DATA_BIT = 8'h80;
    localparam logic [7:0] c_DATA_CNT = 8'd1;
`else
    localparam logic [7:0] c_DATA_BIT = 8'h00;
    localparam logic [7:0] c_DATA_CNT = 8'd0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                clr;
    logic [CH-1:0]       wr_en, rd_en;
    logic [CH-1:0]       full, empty, almostfull, almostempty;
    logic [CH-1:0]       wr_ack, overflow, underflow;
    logic [CH*W-1:0]     data_in, data_out;
    logic [CH*8-1:0]     err_flags;
    logic [CH*CNT_W-1:0] err_cnt;
    logic                err_any;
    logic                first_err_valid;
    logic [1:0]          first_err_ch;
    logic [7:0]          first_err_code;

    int checks = 0;
    int errors = 0;

    // FIFO model state and fault injection controls
    int           m_cnt [CH];
    logic [W-1:0] mq    [CH][$];
    logic [3:0]   cx    [CH];   // xor on full/empty/almostfull/almostempty
    logic [2:0]   rx    [CH];   // xor on wr_ack/overflow/underflow
    logic [W-1:0] dx    [CH];   // xor on read data

    fifo_chk_multi #(
        .CH    (CH),
        .DEPTH (DEPTH),
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .clr             (clr),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .full            (full),
        .empty           (empty),
        .almostfull      (almostfull),
        .almostempty     (almostempty),
        .wr_ack          (wr_ack),
        .overflow        (overflow),
        .underflow       (underflow),
        .data_in         (data_in),
        .data_out        (data_out),
        .err_flags       (err_flags),
        .err_cnt         (err_cnt),
        .err_any         (err_any),
        .first_err_valid (first_err_valid),
        .first_err_ch    (first_err_ch),
        .first_err_code  (first_err_code)
    );

    always #5 clk = ~clk;

    task automatic clear_faults();
        for (int c = 0; c < CH; c++) begin
            cx[c] = '0;
            rx[c] = '0;
            dx[c] = '0;
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0;
            mq[c].delete();
        end
        wr_en    = '0;
        rd_en    = '0;
        wr_ack   = '0;
        overflow = '0;
        underflow = '0;
        data_in  = '0;
        data_out = '0;
        clear_faults();
    endtask

    // One clock: drive flags from the model, take the edge, then update the
    // model's registered responses and occupancy. Returns at posedge+1.
    task automatic step();
        for (int c = 0; c < CH; c++) begin
            full[c]        = (m_cnt[c] == DEPTH)     ^ cx[c][0];
            empty[c]       = (m_cnt[c] == 0)         ^ cx[c][1];
            almostfull[c]  = (m_cnt[c] == DEPTH - 1) ^ cx[c][2];
            almostempty[c] = (m_cnt[c] == 1)         ^ cx[c][3];
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            logic wok, rok;
            wok = wr_en[c] && (m_cnt[c] < DEPTH);
            rok = rd_en[c] && (m_cnt[c] > 0);
            wr_ack[c]    = wok ^ rx[c][0];
            overflow[c]  = (wr_en[c] && (m_cnt[c] == DEPTH)) ^ rx[c][1];
            underflow[c] = (rd_en[c] && (m_cnt[c] == 0)) ^ rx[c][2];
            if (wok) mq[c].push_back(data_in[c*W +: W]);
            if (rok) data_out[c*W +: W] = mq[c].pop_front() ^ dx[c];
            m_cnt[c] = m_cnt[c] + int'(wok) - int'(rok);
        end
    endtask

    task automatic push(input int c, input logic [W-1:0] d);
        wr_en[c] = 1'b1;
        data_in[c*W +: W] = d;
        step();
        wr_en[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        reset_model();
        #12;
        if (err_flags !== '0) begin errors++; $display("FAIL reset_flags got %h exp 0", err_flags); end
        checks++;
        if (err_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h exp 0", err_cnt); end
        checks++;
        if ({err_any, first_err_valid, first_err_ch, first_err_code} !== 12'h000) begin
            errors++;
            $display("FAIL reset_misc got any=%b v=%b ch=%0d code=%h exp all 0",
                     err_any, first_err_valid, first_err_ch, first_err_code);
        end
        checks++;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) push(0, 16'h1000 + 16'(i));
        step();   // idle at count 8: a correct full flag must not flag
        if (err_flags !== '0) begin errors++; $display("FAIL fill_flags got %h exp 0", err_flags); end
        checks++;
        if (err_cnt !== '0) begin errors++; $display("FAIL fill_cnt got %h exp 0", err_cnt); end
        checks++;
        if (err_any !== 1'b0) begin errors++; $display("FAIL fill_any got %b exp 0", err_any); end
        checks++;
    endtask

    task automatic test_full_flag();
        for (int i = 0; i < DEPTH; i++) push(1, 16'h2000 + 16'(i));
        cx[1] = 4'b0001;
        step();
        clear_faults();
        if (err_flags !== 32'h0000_0100) begin errors++; $display("FAIL full_flags got %h exp 00000100", err_flags); end
        checks++;
        if (err_cnt !== 32'h0000_0100) begin errors++; $display("FAIL full_cnt got %h exp 00000100", err_cnt); end
        checks++;
        if (first_err_valid !== 1'b1 || first_err_ch !== 2'd1 || first_err_code !== 8'h01) begin
            errors++;
            $display("FAIL full_first got v=%b ch=%0d code=%h exp v=1 ch=1 code=01",
                     first_err_valid, first_err_ch, first_err_code);
        end
        checks++;
        if (err_any !== 1'b1) begin errors++; $display("FAIL full_any got %b exp 1", err_any); end
        checks++;
    endtask

    task automatic test_overflow();
        wr_en[0] = 1'b1;
        rx[0]    = 3'b010;   // model reports overflow=0 although FIFO is full
        step();
        wr_en[0] = 1'b0;
        clear_faults();
        if (err_flags[7:0] !== 8'h00) begin errors++; $display("FAIL ovf_early got %h exp 00", err_flags[7:0]); end
        checks++;
        step();
        if (err_flags[7:0] !== 8'h20) begin errors++; $display("FAIL ovf_flags got %h exp 20", err_flags[7:0]); end
        checks++;
        if (err_cnt[7:0] !== 8'd1) begin errors++; $display("FAIL ovf_cnt got %0d exp 1", err_cnt[7:0]); end
        checks++;
        if (first_err_ch !== 2'd1) begin errors++; $display("FAIL ovf_first_ch got %0d exp 1", first_err_ch); end
        checks++;
    endtask

    task automatic test_almostfull();
        for (int i = 0; i < DEPTH; i++) push(2, 16'h3000 + 16'(i));
        wr_en[2] = 1'b1;
        rd_en[2] = 1'b1;
        step();              // at full only the read is accepted -> 7
        wr_en[2] = 1'b0;
        rd_en[2] = 1'b0;
        cx[2] = 4'b0100;     // almostfull expected 1, drive 0
        step();
        clear_faults();
        if (err_flags[23:16] !== 8'h04) begin errors++; $display("FAIL afull_flags got %h exp 04", err_flags[23:16]); end
        checks++;
        if (err_cnt[23:16] !== 8'd1) begin errors++; $display("FAIL afull_cnt got %0d exp 1", err_cnt[23:16]); end
        checks++;
    endtask

    task automatic test_priority_sat_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        if (err_flags !== '0 || err_cnt !== '0 || first_err_valid !== 1'b0 || err_any !== 1'b0) begin
            errors++;
            $display("FAIL clr1 got flags=%h cnt=%h v=%b any=%b exp all 0",
                     err_flags, err_cnt, first_err_valid, err_any);
        end
        checks++;
        cx[2] = 4'b0010;     // ch2 empty wrong (count 7)
        cx[3] = 4'b0001;     // ch3 full wrong (count 0)
        step();
        cx[2] = 4'b0000;
        if (first_err_ch !== 2'd2 || first_err_code !== 8'h02) begin
            errors++;
            $display("FAIL prio_first got ch=%0d code=%h exp ch=2 code=02", first_err_ch, first_err_code);
        end
        checks++;
        if (err_flags !== 32'h0102_0000) begin errors++; $display("FAIL prio_flags got %h exp 01020000", err_flags); end
        checks++;
        repeat (100) step();
        if (err_cnt[31:24] !== 8'd101) begin errors++; $display("FAIL sat_mid got %0d exp 101", err_cnt[31:24]); end
        checks++;
        repeat (200) step();
        if (err_cnt[31:24] !== 8'd255) begin errors++; $display("FAIL sat_end got %0d exp 255", err_cnt[31:24]); end
        checks++;
        if (first_err_ch !== 2'd2) begin errors++; $display("FAIL sat_first_ch got %0d exp 2", first_err_ch); end
        checks++;
        clr = 1'b1;          // ch3 still mismatching: clear must win
        step();
        clr = 1'b0;
        if (err_flags !== '0 || err_cnt !== '0 || first_err_valid !== 1'b0 || err_any !== 1'b0) begin
            errors++;
            $display("FAIL clr2 got flags=%h cnt=%h v=%b any=%b exp all 0",
                     err_flags, err_cnt, first_err_valid, err_any);
        end
        checks++;
        repeat (3) step();
        if (err_cnt[31:24] !== 8'd3) begin errors++; $display("FAIL burst_cnt got %0d exp 3", err_cnt[31:24]); end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (err_flags !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL arst_vec got flags=%h cnt=%h exp 0", err_flags, err_cnt);
        end
        checks++;
        if ({err_any, first_err_valid, first_err_ch, first_err_code} !== 12'h000) begin
            errors++;
            $display("FAIL arst_misc got any=%b v=%b ch=%0d code=%h exp all 0",
                     err_any, first_err_valid, first_err_ch, first_err_code);
        end
        checks++;
        reset_model();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_enable();
        en    = 1'b0;
        cx[1] = 4'b0010;     // ch1 empty wrong while checks disabled
        push(1, 16'h4444);   // shadow model must still count this write
        clear_faults();
        en = 1'b1;
        step();              // count 1: correct almostempty must pass
        if (err_flags !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL enable got flags=%h cnt=%h exp 0", err_flags, err_cnt);
        end
        checks++;
    endtask

    task automatic test_data();
        push(0, 16'hA5A5);
        rd_en[0] = 1'b1;
        dx[0]    = 16'h0001; // FIFO returns A5A4
        step();
        rd_en[0] = 1'b0;
        clear_faults();
        step();
        if (err_flags[7:0] !== c_DATA_BIT) begin
            errors++;
            $display("FAIL data_flags got %h exp %h", err_flags[7:0], c_DATA_BIT);
        end
        checks++;
        if (err_cnt[7:0] !== c_DATA_CNT) begin
            errors++;
            $display("FAIL data_cnt got %0d exp %0d", err_cnt[7:0], c_DATA_CNT);
        end
        checks++;
        if (first_err_code !== c_DATA_BIT) begin
            errors++;
            $display("FAIL data_first got %h exp %h", first_err_code, c_DATA_BIT);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_flag();
        test_overflow();
        test_almostfull();
        test_priority_sat_clr();
        test_enable();
        test_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_chk_multi.md
# fifo_chk_multi

Synthesizable, parametrised multi-channel FIFO protocol checker. It shadows up to CH independent FIFOs by observing their write/read strobes, and builds a reference occupancy model per channel. Every cycle it checks each DUT's status flags and registered responses against that model. Results are latched in sticky per-channel error vectors, saturating error counters and a first-error capture. It sits beside the FIFO instances in both bench and silicon debug builds, on the same clock and reset.

## Interface
- CH, 4, number of monitored FIFO channels
- DEPTH, 8, depth of each monitored FIFO
- W, 16, data width per channel
- CNT_W, 8, width of each per-channel error counter
- clk  in  1  rising-edge clock, shared with monitored FIFOs
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  check enable; shadow model tracks regardless
- clr  in  1  synchronous clear of error state (sticky vectors, counters, first-error)
- wr_en, rd_en  in  CH  per-channel strobes driven to the DUTs
- full, empty, almostfull, almostempty  in  CH  DUT combinational flags
- wr_ack, overflow, underflow  in  CH  DUT registered responses
- data_in, data_out  in  CH*W  DUT data, channel c at [c*W +: W]
- err_flags  out  CH*8  sticky per-channel error vector
- err_cnt  out  CH*CNT_W  per-channel error-cycle counters
- err_any  out  1  OR of all err_flags
- first_err_valid  out  1  first-error capture is valid
- first_err_ch  out  $clog2(CH)  channel of the first error
- first_err_code  out  8  error vector of the first error

## Operation
- Error bit map: 0 full, 1 empty, 2 almostfull, 3 almostempty, 4 wr_ack, 5 overflow, 6 underflow, 7 data.
- Shadow count per channel, width $clog2(DEPTH+1):
  - wr_ok = wr_en & (cnt<DEPTH)
  - rd_ok = rd_en & (cnt>0)
  - cnt_next = cnt + wr_ok - rd_ok
- At full with wr_en=1 and rd_en=1, only the read is accepted.
- At empty with wr_en=1 and rd_en=1, only the write is accepted.
- Combinational expectations are computed from cnt before the update:
  - full = (cnt==DEPTH)
  - empty = (cnt==0)
  - almostfull = (cnt==DEPTH-1)
  - almostempty = (cnt==1)
- Registered expectations are latched at edge k and compared at edge k+1:
  - wr_ack = wr_ok
  - overflow = wr_en & full_exp
  - underflow = rd_en & empty_exp
- Registered checks are masked until one sampling edge has occurred after reset.
- A mismatch on channel c with en=1 sets the matching err_flags bits; sticky until clr or reset.
- err_cnt[c] increments by 1 per cycle with any mismatch on c (not per bit). It saturates at 2^CNT_W-1.
- First error: on the first mismatching cycle, capture the lowest-index erring channel and its full 8-bit mismatch vector. Hold until clr.
- clr=1 takes precedence over new errors in the same cycle. The shadow count is untouched by clr.

## Timing
- All outputs are registered. A mismatch sampled at edge k is visible on the outputs after edge k.
- Registered-response checks therefore report one edge after the causing strobe.
- Reset mid-operation clears cnt, all outputs and the warm-up mask immediately, asynchronously.
- Reset value of every output is 0.

## Configuration
- Macro: FIFO_CHK_DATA_EN.
- Defined:
  - Each channel holds a DEPTH x W shadow RAM with wrapping pointers. Write is on wr_ok; read is on rd_ok.
  - The expected data_out is registered on rd_ok and compared at the next edge.
  - A mismatch sets bit 7.
- Undefined:
  - No shadow RAM is built and data_in/data_out are ignored.
  - Bit 7 is tied to 0.

## Structure
- Package fifo_chk_pkg holds:
  - localparams ERR_FULL..ERR_DATA (bit indices 0..7)
  - typedef err_vec_t (logic [7:0])
- Sub-module fifo_chk_chan holds one channel's shadow count, optional RAM, expectations, sticky vector and counter. It is generated CH times.
- The top holds the priority first-error capture and err_any.

## Test plan
- Reset; write 8 words into ch0 with a correct DUT model -> err_flags=0, err_cnt=0, cnt ends at 8.
- ch1 at cnt=8 with full driven 0 -> next edge: err_flags[ch1]=8'h01, err_cnt[ch1]=1, first_err_ch=1, first_err_code=8'h01.
- ch0 at cnt=8 with wr_en=1 and overflow held 0 next cycle -> bit 5 set one edge after the strobe, bit 4 clear.
- ch2 at cnt=8 with wr_en=1, rd_en=1 -> cnt=7; almostfull=1 expected next cycle; driving 0 sets bit 2.
- Mismatches on ch2 and ch3 on the same edge -> first_err_ch=2. Then 300 error cycles on ch3 -> err_cnt[ch3]=255. Then clr -> all error state 0. Assert rst_n mid-burst -> all outputs 0 asynchronously.
- With FIFO_CHK_DATA_EN: write 16'hA5A5 to ch0, read it, drive data_out=16'hA5A4 -> bit 7 set. Without the macro, the same stimulus leaves bit 7 at 0.
